// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported synchronous memory between the instruction-fetch
//   requester (I) and the load/store requester (D). Only one transaction is in
//   flight at a time. D has fixed priority. A starvation counter forces an I
//   grant after STARVE_LIMIT consecutive lost arbitrations.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr             fetch request (held until i_ack)
//   i_ack/i_rdata            one-cycle completion pulse, fetched word
//   d_req/d_we/d_addr/d_wdata  load/store request (held until d_ack)
//   d_ack/d_rdata            one-cycle completion pulse, load data (0 after a store)
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and command, one cycle per access
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
//   busy                     high whenever a transaction is in progress
//
// Every output is registered.

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state;
  logic        win_d;
  logic        is_store;
  logic [3:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        grant_d;

  // D wins whenever it asks, unless I is also asking and has already lost
  // STARVE_LIMIT arbitrations in a row.
  always_comb begin
    grant_d = d_req && (!i_req || (starve_cnt < STARVE_MAX));
  end

  // mem_en/mem_we are raised on the IDLE->ISSUE edge so that, being
  // registered, they are visible exactly during the ISSUE cycle. Likewise
  // the acks are raised on the WAIT->RESP edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      win_d      <= 1'b0;
      is_store   <= 1'b0;
      lat_cnt    <= 4'd0;
      starve_cnt <= 4'd0;
      i_ack      <= 1'b0;
      i_rdata    <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_req) begin
            starve_cnt <= 4'd0;
          end
          if (i_req || d_req) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (grant_d) begin
              win_d     <= 1'b1;
              is_store  <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // Only a contested loss counts towards starvation.
              if (i_req && (starve_cnt != 4'hF)) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end else begin
              win_d      <= 1'b0;
              is_store   <= 1'b0;
              mem_addr   <= i_addr;
              starve_cnt <= 4'd0;
            end
          end
        end

        ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end

        // Stores wait the full latency too, so completion timing does not
        // depend on the kind of access.
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            state <= RESP;
            if (win_d) begin
              d_ack   <= 1'b1;
              d_rdata <= is_store ? '0 : mem_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
